// File: rtl/mtm_alu_deserializer.sv
// rtl/mtm_alu_deserializer.sv - serial frame receiver and packet checker for the mtm_Alu (optional MTM_DESER_TIMEOUT_EN)
module mtm_alu_deserializer #(
    parameter int DATA_FRAMES    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        out_valid,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RX   = 2'd1;
    localparam logic [1:0] ST_EVAL = 2'd2;

    localparam logic [3:0] FRAMES_REQ = 4'(DATA_FRAMES);
    localparam int         TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef MTM_DESER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          frm_type;
    logic [63:0]   ba;
    logic [3:0]    data_cnt;
    logic          bad_frame;
    logic [3:0]    crc;
    logic [TW-1:0] idle_cnt;

    // Bits 1..10 of the frame as seen on the stop-bit edge: {type, payload[7:0], stop}
    logic [9:0] frame;
    logic       is_cmd;
    logic       stop_ok;
    logic [7:0] payload;
    logic [2:0] op_rx;
    logic [3:0] crc_rx;

    assign frame   = {shreg, sin};
    assign is_cmd  = frame[9];
    assign payload = frame[8:1];
    assign stop_ok = frame[0];
    assign op_rx   = payload[6:4];
    assign crc_rx  = payload[3:0];

    logic       crc_en;
    logic       crc_bit;
    logic       crc_fb;
    logic [3:0] crc_next;

    // Select which received bit feeds the CRC: every data payload bit, or the implicit 1 plus op bits of a command
    always_comb begin
        crc_en  = 1'b0;
        crc_bit = sin;
        if (state == ST_RX && bit_cnt >= 4'd2 && bit_cnt <= 4'd9) begin
            if (!frm_type) begin
                crc_en = 1'b1;
            end else if (bit_cnt == 4'd2) begin
                crc_en  = 1'b1;
                crc_bit = 1'b1;
            end else if (bit_cnt <= 4'd5) begin
                crc_en = 1'b1;
            end
        end
    end

    // x^4 + x + 1 LFSR, one message bit per step, MSB first
    assign crc_fb   = crc[3] ^ crc_bit;
    assign crc_next = {crc[2], crc[1], crc[0] ^ crc_fb, crc_fb};

    // Frame FSM; the verdict is registered on the stop-bit edge so the pulse occupies the EVAL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 9'd0;
            frm_type  <= 1'b0;
            ba        <= 64'd0;
            data_cnt  <= 4'd0;
            bad_frame <= 1'b0;
            crc       <= 4'd0;
            idle_cnt  <= '0;
            a_out     <= 32'd0;
            b_out     <= 32'd0;
            op_out    <= 3'd0;
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= 3'd0;
        end else begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= 3'd0;
            if (crc_en) begin
                crc <= crc_next;
            end
            case (state)
                ST_IDLE: begin
                    if (!sin) begin
                        state   <= ST_RX;
                        bit_cnt <= 4'd1;
                    end
                    if (data_cnt != 4'd0) begin
                        if (TIMEOUT_EN && idle_cnt == TO_LAST) begin
                            data_cnt  <= 4'd0;
                            bad_frame <= 1'b0;
                            crc       <= 4'd0;
                            idle_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                ST_RX: begin
                    idle_cnt <= '0;
                    shreg    <= {shreg[7:0], sin};
                    bit_cnt  <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd1) begin
                        frm_type <= sin;
                    end
                    if (bit_cnt == 4'd10) begin
                        state <= ST_EVAL;
                        if (!stop_ok) begin
                            bad_frame <= 1'b1;
                        end else if (!is_cmd) begin
                            ba <= {ba[55:0], payload};
                            if (data_cnt != 4'hF) begin
                                data_cnt <= data_cnt + 4'd1;
                            end
                        end else begin
                            data_cnt  <= 4'd0;
                            bad_frame <= 1'b0;
                            crc       <= 4'd0;
                            if (data_cnt != FRAMES_REQ || bad_frame) begin
                                err_valid <= 1'b1;
                                err_flags <= 3'b100;
                            end else if (crc != crc_rx) begin
                                err_valid <= 1'b1;
                                err_flags <= 3'b010;
                            end else if (op_rx[1]) begin
                                err_valid <= 1'b1;
                                err_flags <= 3'b001;
                            end else begin
                                out_valid <= 1'b1;
                                b_out     <= ba[63:32];
                                a_out     <= ba[31:0];
                                op_out    <= op_rx;
                            end
                        end
                    end
                end
                ST_EVAL: begin
                    idle_cnt <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb/tb_mtm_alu_deserializer.sv - self-checking bench for mtm_alu_deserializer
module tb_mtm_alu_deserializer;

    localparam int DF = 8;
    localparam int TO = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic        out_valid;
    logic        err_valid;
    logic [2:0]  err_flags;

    mtm_alu_deserializer #(
        .DATA_FRAMES   (DF),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (sin),
        .a_out    (a_out),
        .b_out    (b_out),
        .op_out   (op_out),
        .out_valid(out_valid),
        .err_valid(err_valid),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ov  = 0;
    int n_er  = 0;

    logic [31:0] exp_a  = 32'd0;
    logic [31:0] exp_b  = 32'd0;
    logic [2:0]  exp_op = 3'd0;

    typedef struct {
        int          nfr;
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  cx;
        logic [3:0]  exp;
    } vec_t;

    vec_t tbl[8];

    // Pulse counters, read as deltas by the checking tasks
    always @(negedge clk) begin
        if (out_valid) n_ov++;
        if (err_valid) n_er++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Remainder of (msg * x^4) modulo x^4+x+1 by long division
    function automatic logic [3:0] crc4_ref(input logic [67:0] v);
        logic [71:0] r;
        r = {v, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    // {valid, err_flags[2:0]} expected for a packet
    function automatic logic [3:0] model(input int n, input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] op, input logic [3:0] crc, input logic bad);
        if (n != DF || bad) return 4'b0100;
        if (crc != crc4_ref({b, a, 1'b1, op})) return 4'b0010;
        if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) return 4'b0001;
        return 4'b1000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
        @(negedge clk) sin = 1'b0;
        @(negedge clk) sin = typ;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk) sin = pl[i];
        end
        @(negedge clk) sin = stop;
    endtask

    task automatic send_data(input logic [7:0] pl, input logic stop);
        send_frame(1'b0, pl, stop);
        @(negedge clk) sin = 1'b1;
    endtask

    task automatic send_bytes(input int n, input logic [31:0] b, input logic [31:0] a);
        logic [63:0] v;
        v = {b, a};
        for (int k = 0; k < n - DF; k++) send_data(8'($urandom), 1'b1);
        for (int k = 0; k < n && k < DF; k++) send_data(v[63 - 8*k -: 8], 1'b1);
    endtask

    task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] crc,
                           input logic [3:0] exp, input int ov0, input int er0);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
        @(negedge clk) sin = 1'b1;
        check({name, " pulse"}, {out_valid, err_valid, err_flags}, {exp[3], ~exp[3], exp[2:0]});
        if (exp[3]) begin
            exp_a  = 0;
            exp_a  = exp_a;
        end
        @(negedge clk);
        check({name, " clear"}, {out_valid, err_valid, err_flags}, 5'd0);
        repeat (2) @(negedge clk);
        check({name, " count"}, (n_ov - ov0) + (n_er - er0), 1);
    endtask

    task automatic run_packet(input string name, input int n, input logic [31:0] b, input logic [31:0] a,
                              input logic [2:0] op, input logic [3:0] crc, input logic [3:0] exp);
        int ov0;
        int er0;
        ov0 = n_ov;
        er0 = n_er;
        send_bytes(n, b, a);
        run_cmd(name, op, crc, exp, ov0, er0);
        if (exp[3]) begin
            exp_a  = a;
            exp_b  = b;
            exp_op = op;
        end
        check({name, " data"}, {a_out, b_out, op_out}, {exp_a, exp_b, exp_op});
    endtask

    initial begin
        logic [3:0] crc;
        logic [3:0] e;
        logic [31:0] rb;
        logic [31:0] ra;
        logic [2:0] rop;
        int n;
        int ov0;
        int er0;

        tbl[0] = '{8, 32'd2,          32'd1,          3'b100, 4'h0, 4'b1000};
        tbl[1] = '{8, 32'd2,          32'd1,          3'b100, 4'h1, 4'b0010};
        tbl[2] = '{7, 32'd2,          32'd1,          3'b011, 4'h1, 4'b0100};
        tbl[3] = '{8, 32'h1234_5678,  32'h9ABC_DEF0,  3'b011, 4'h0, 4'b0001};
        tbl[4] = '{9, 32'hDEAD_BEEF,  32'h0BAD_F00D,  3'b000, 4'h0, 4'b0100};
        tbl[5] = '{8, 32'hCAFE_0001,  32'h8000_0000,  3'b001, 4'h0, 4'b1000};
        tbl[6] = '{8, 32'h0000_FFFF,  32'h5555_AAAA,  3'b101, 4'h8, 4'b0010};
        tbl[7] = '{8, 32'h0F0F_0F0F,  32'h7777_0000,  3'b111, 4'h0, 4'b0001};

        repeat (3) @(negedge clk);
        check("reset outputs", {a_out, b_out, op_out, out_valid, err_valid, err_flags}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            crc = crc4_ref({tbl[i].b, tbl[i].a, 1'b1, tbl[i].op}) ^ tbl[i].cx;
            run_packet($sformatf("vec%0d", i), tbl[i].nfr, tbl[i].b, tbl[i].a, tbl[i].op, crc, tbl[i].exp);
        end

        // Good packet with one extra frame whose stop bit is 0
        ov0 = n_ov;
        er0 = n_er;
        send_data(8'hA5, 1'b0);
        send_bytes(8, 32'h1111_2222, 32'h3333_4444);
        run_cmd("bad stop", 3'b000, crc4_ref({32'h1111_2222, 32'h3333_4444, 1'b1, 3'b000}), 4'b0100, ov0, er0);
        check("bad stop data", {a_out, b_out, op_out}, {exp_a, exp_b, exp_op});

        // Randomized packets against the reference model
        for (int i = 0; i < 30; i++) begin
            rb  = $urandom;
            ra  = $urandom;
            rop = 3'($urandom_range(0, 7));
            n   = (i % 6 == 0) ? 7 : ((i % 6 == 3) ? 9 : 8);
            crc = crc4_ref({rb, ra, 1'b1, rop});
            if ($urandom_range(0, 2) == 0) crc = crc ^ 4'($urandom_range(1, 15));
            e = model(n, rb, ra, rop, crc, 1'b0);
            run_packet($sformatf("rand%0d", i), n, rb, ra, rop, crc, e);
        end

        // Reset in the middle of a packet
        ov0 = n_ov;
        er0 = n_er;
        send_bytes(5, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_a  = 32'd0;
        exp_b  = 32'd0;
        exp_op = 3'd0;
        check("mid reset outputs", {a_out, b_out, op_out, out_valid, err_valid, err_flags}, 0);
        check("mid reset no pulse", (n_ov - ov0) + (n_er - er0), 0);
        run_packet("after reset", 8, 32'h0, 32'hFFFF_FFFF, 3'b101,
                   crc4_ref({32'h0, 32'hFFFF_FFFF, 1'b1, 3'b101}), 4'b1000);

        // Partial packet followed by a long idle period
        ov0 = n_ov;
        er0 = n_er;
        send_bytes(3, 32'hABCD_EF01, 32'h0);
        repeat (TO + 1) @(negedge clk);
        check("idle no pulse", (n_ov - ov0) + (n_er - er0), 0);
`ifdef MTM_DESER_TIMEOUT_EN
        e = 4'b1000;
`else
        e = 4'b0100;
`endif
        run_packet("timeout", 8, 32'h2468_ACE0, 32'h1357_9BDF, 3'b001,
                   crc4_ref({32'h2468_ACE0, 32'h1357_9BDF, 1'b1, 3'b001}), e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
